// File: rtl/rs_encode_line_in_ctrl.sv
// rs_encode_line_in_ctrl
// Input-side line controller for the Reed-Solomon encoder. It latches one
// input line at a time and presents it to the encoder core one byte per cycle,
// starting with byte 0 (the MSB end). It flags the last data byte of the
// codeword. It then waits for the line-out controller's done handshake before
// it accepts the next codeword.
module rs_encode_line_in_ctrl #(
  parameter int LINE_BYTES = 32,
  parameter int DATA_BYTES = 223,
  localparam int LINE_W    = 8 * LINE_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_encoder_line_val,
  output logic              encoder_src_line_rdy,
  input  logic [LINE_W-1:0] src_encoder_line_data,
  output logic              in_ctrl_encoder_byte_val,
  input  logic              encoder_in_ctrl_byte_rdy,
  output logic [7:0]        in_ctrl_encoder_byte,
  output logic              in_ctrl_encoder_byte_last,
  output logic              in_ctrl_out_ctrl_done,
  input  logic              out_ctrl_in_ctrl_done
);

  localparam int IDX_W = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int CNT_W = $clog2(DATA_BYTES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_BYTES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    S_READY,
    S_SEND_BYTES,
    S_LINE_IN_WAIT,
    S_DONE_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] w_line_nxt;
  logic [IDX_W-1:0]  r_byte_idx;
  logic [IDX_W-1:0]  w_byte_idx_nxt;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [CNT_W-1:0]  w_byte_cnt_nxt;
  logic [LINE_W-1:0] w_line_shifted;

  // State and datapath registers. Reset abandons any partial codeword.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_READY;
      r_line     <= '0;
      r_byte_idx <= '0;
      r_byte_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments here let all registers update
      // together from the values sampled at the edge, which avoids
      // simulation ordering races.
      r_state    <= w_state_nxt;
      r_line     <= w_line_nxt;
      r_byte_idx <= w_byte_idx_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
    end
  end

  // Next-state logic and Moore outputs. The outputs are decoded from the
  // state and the byte counter only.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would infer a latch.
    w_state_nxt               = r_state;
    w_line_nxt                = r_line;
    w_byte_idx_nxt            = r_byte_idx;
    w_byte_cnt_nxt            = r_byte_cnt;
    encoder_src_line_rdy      = 1'b0;
    in_ctrl_encoder_byte_val  = 1'b0;
    in_ctrl_encoder_byte_last = 1'b0;
    in_ctrl_out_ctrl_done     = 1'b0;

    case (r_state)
      S_READY: begin
        encoder_src_line_rdy = 1'b1;
        if (src_encoder_line_val) begin
          w_line_nxt     = src_encoder_line_data;
          w_byte_idx_nxt = '0;
          w_byte_cnt_nxt = '0;
          w_state_nxt    = S_SEND_BYTES;
        end
      end

      S_SEND_BYTES: begin
        in_ctrl_encoder_byte_val  = 1'b1;
        in_ctrl_encoder_byte_last = (r_byte_cnt == LAST_CNT);
        if (encoder_in_ctrl_byte_rdy) begin
          if (r_byte_cnt == LAST_CNT) begin
            // The codeword is complete. Leftover bytes of this line are dropped.
            w_state_nxt = S_DONE_WAIT;
          end else if (r_byte_idx == LAST_IDX) begin
            w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
            w_byte_idx_nxt = '0;
            w_state_nxt    = S_LINE_IN_WAIT;
          end else begin
            w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
            w_byte_idx_nxt = r_byte_idx + IDX_W'(1);
          end
        end
      end

      S_LINE_IN_WAIT: begin
        encoder_src_line_rdy = 1'b1;
        if (src_encoder_line_val) begin
          w_line_nxt  = src_encoder_line_data;
          w_state_nxt = S_SEND_BYTES;
        end
      end

      S_DONE_WAIT: begin
        in_ctrl_out_ctrl_done = 1'b1;
        if (out_ctrl_in_ctrl_done) begin
          w_byte_cnt_nxt = '0;
          w_byte_idx_nxt = '0;
          w_state_nxt    = S_READY;
        end
      end

      default: begin
        w_state_nxt               = state_t'('x);
        w_line_nxt                = 'x;
        w_byte_idx_nxt            = 'x;
        w_byte_cnt_nxt            = 'x;
        encoder_src_line_rdy      = 1'bx;
        in_ctrl_encoder_byte_val  = 1'bx;
        in_ctrl_encoder_byte_last = 1'bx;
        in_ctrl_out_ctrl_done     = 1'bx;
      end
    endcase
  end

  // Byte select. Byte 0 sits at the MSB end, so shift the selected byte to the top.
  assign w_line_shifted       = r_line << {r_byte_idx, 3'b000};
  assign in_ctrl_encoder_byte = w_line_shifted[LINE_W-1 -: 8];

  // Line intake and byte delivery never overlap.
  a_val_rdy_excl : assert property (@(posedge clk) disable iff (!rst)
    !(in_ctrl_encoder_byte_val && encoder_src_line_rdy));

  // A stalled byte keeps its data and its last flag.
  a_byte_stable : assert property (@(posedge clk) disable iff (!rst)
    (in_ctrl_encoder_byte_val && !encoder_in_ctrl_byte_rdy) |=>
      ($stable(in_ctrl_encoder_byte) && $stable(in_ctrl_encoder_byte_last)));

endmodule

// File: tb/tb_rs_encode_line_in_ctrl.sv
// Testbench for rs_encode_line_in_ctrl: default-size instance (32-byte lines,
// 223-byte codewords) plus a small instance (1-byte lines, 3-byte codewords).
module tb_rs_encode_line_in_ctrl;

  localparam int LB = 32;
  localparam int DB = 223;
  localparam int LW = 8 * LB;
  localparam int BOUND = 2000;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          src_encoder_line_val;
  logic          encoder_src_line_rdy;
  logic [LW-1:0] src_encoder_line_data;
  logic          in_ctrl_encoder_byte_val;
  logic          encoder_in_ctrl_byte_rdy;
  logic [7:0]    in_ctrl_encoder_byte;
  logic          in_ctrl_encoder_byte_last;
  logic          in_ctrl_out_ctrl_done;
  logic          out_ctrl_in_ctrl_done;

  logic       s_line_val;
  logic       s_line_rdy;
  logic [7:0] s_line_data;
  logic       s_byte_val;
  logic       s_byte_rdy;
  logic [7:0] s_byte;
  logic       s_byte_last;
  logic       s_done;
  logic       s_peer_done;

  int   n_vec = 0;
  int   n_mis = 0;
  int   cyc = 0;
  int   done_cycles = 0;
  logic rand_rdy = 1'b0;
  exp_t q[$];
  exp_t sq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rs_encode_line_in_ctrl #(.LINE_BYTES(LB), .DATA_BYTES(DB)) u_dut (
    .clk                       (clk),
    .rst                       (rst),
    .src_encoder_line_val      (src_encoder_line_val),
    .encoder_src_line_rdy      (encoder_src_line_rdy),
    .src_encoder_line_data     (src_encoder_line_data),
    .in_ctrl_encoder_byte_val  (in_ctrl_encoder_byte_val),
    .encoder_in_ctrl_byte_rdy  (encoder_in_ctrl_byte_rdy),
    .in_ctrl_encoder_byte      (in_ctrl_encoder_byte),
    .in_ctrl_encoder_byte_last (in_ctrl_encoder_byte_last),
    .in_ctrl_out_ctrl_done     (in_ctrl_out_ctrl_done),
    .out_ctrl_in_ctrl_done     (out_ctrl_in_ctrl_done)
  );

  rs_encode_line_in_ctrl #(.LINE_BYTES(1), .DATA_BYTES(3)) u_small (
    .clk                       (clk),
    .rst                       (rst),
    .src_encoder_line_val      (s_line_val),
    .encoder_src_line_rdy      (s_line_rdy),
    .src_encoder_line_data     (s_line_data),
    .in_ctrl_encoder_byte_val  (s_byte_val),
    .encoder_in_ctrl_byte_rdy  (s_byte_rdy),
    .in_ctrl_encoder_byte      (s_byte),
    .in_ctrl_encoder_byte_last (s_byte_last),
    .in_ctrl_out_ctrl_done     (s_done),
    .out_ctrl_in_ctrl_done     (s_peer_done)
  );

  // One comparison: counts it, and on a mismatch counts and reports it.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encoder-core ready: tied high, or random at 50% when rand_rdy is set.
  initial begin
    encoder_in_ctrl_byte_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      encoder_in_ctrl_byte_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor for the default instance: scoreboard pop on each byte handshake, stall stability.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte;
  logic       prev_last;
  exp_t       e;
  always @(negedge clk) begin
    if (in_ctrl_out_ctrl_done) done_cycles++;
    if (rst && prev_stall) begin
      check("stall_val", in_ctrl_encoder_byte_val, 1);
      check("stall_byte", in_ctrl_encoder_byte, prev_byte);
      check("stall_last", in_ctrl_encoder_byte_last, prev_last);
    end
    if (rst && in_ctrl_encoder_byte_val && encoder_in_ctrl_byte_rdy) begin
      check("byte_expected", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("byte", in_ctrl_encoder_byte, e.b);
        check("last", in_ctrl_encoder_byte_last, e.last);
      end
    end
    prev_stall = rst && in_ctrl_encoder_byte_val && !encoder_in_ctrl_byte_rdy;
    prev_byte  = in_ctrl_encoder_byte;
    prev_last  = in_ctrl_encoder_byte_last;
  end

  // Monitor for the small instance.
  exp_t se;
  always @(negedge clk) begin
    if (rst && s_byte_val && s_byte_rdy) begin
      check("s_byte_expected", sq.size() != 0, 1);
      if (sq.size() != 0) begin
        se = sq.pop_front();
        check("s_byte", s_byte, se.b);
        check("s_last", s_byte_last, se.last);
      end
    end
  end

  // Offer line l of a codeword and push its expected bytes. Returns the cycle stamp of acceptance.
  task automatic send_line(input int l, output int t_acc);
    logic [LW-1:0] d;
    int k;
    int c;
    d = '0;
    for (int i = 0; i < LB; i++) begin
      c = l * LB + i;
      d[LW-1-8*i -: 8] = 8'(c);
      if (c < DB) q.push_back('{b: 8'(c), last: (c == DB - 1)});
    end
    @(posedge clk);
    #1;
    src_encoder_line_val  = 1'b1;
    src_encoder_line_data = d;
    @(negedge clk);
    k = 0;
    while (!encoder_src_line_rdy && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    check("line_accept", encoder_src_line_rdy, 1);
    @(posedge clk);
    #1;
    t_acc = cyc;
    src_encoder_line_val  = 1'b0;
    src_encoder_line_data = '0;
    @(negedge clk);
    check("first_byte_val", in_ctrl_encoder_byte_val, 1);
    check("line_rdy_busy", encoder_src_line_rdy, 0);
  endtask

  // Wait (bounded) for the done request. Returns the cycle stamp when it is first seen.
  task automatic wait_done(output int t_seen);
    int k;
    k = 0;
    while (!in_ctrl_out_ctrl_done && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", in_ctrl_out_ctrl_done, 1);
    check("done_line_rdy", encoder_src_line_rdy, 0);
    t_seen = cyc;
  endtask

  // Offer one line to the small instance.
  task automatic send_small(input logic [7:0] b, input logic last);
    int k;
    sq.push_back('{b: b, last: last});
    @(posedge clk);
    #1;
    s_line_val  = 1'b1;
    s_line_data = b;
    @(negedge clk);
    k = 0;
    while (!s_line_rdy && k < BOUND) begin
      @(negedge clk);
      k++;
    end
    check("s_line_accept", s_line_rdy, 1);
    @(posedge clk);
    #1;
    s_line_val = 1'b0;
    @(negedge clk);
    check("s_first_byte_val", s_byte_val, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int td;
    int tl;

    // Reset state of both instances.
    rst                   = 1'b0;
    src_encoder_line_val  = 1'b0;
    src_encoder_line_data = '0;
    out_ctrl_in_ctrl_done = 1'b0;
    s_line_val            = 1'b0;
    s_line_data           = '0;
    s_byte_rdy            = 1'b1;
    s_peer_done           = 1'b0;
    #1;
    check("rst_line_rdy", encoder_src_line_rdy, 1);
    check("rst_byte_val", in_ctrl_encoder_byte_val, 0);
    check("rst_byte", in_ctrl_encoder_byte, 0);
    check("rst_last", in_ctrl_encoder_byte_last, 0);
    check("rst_done", in_ctrl_out_ctrl_done, 0);
    check("rst_s_line_rdy", s_line_rdy, 1);
    check("rst_s_done", s_done, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    // Codeword 1: ready tied high, exact timing, and the peer's done arrives 5 cycles late.
    send_line(0, t0);
    for (int l = 1; l < 7; l++) send_line(l, tl);
    wait_done(td);
    check("cw1_latency", td - t0, 229);
    check("cw1_queue_empty", q.size(), 0);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      check("dly_done_high", in_ctrl_out_ctrl_done, 1);
      check("dly_line_rdy_low", encoder_src_line_rdy, 0);
    end
    @(posedge clk);
    #1;
    out_ctrl_in_ctrl_done = 1'b1;
    @(negedge clk);
    check("dly_done_cycle6", in_ctrl_out_ctrl_done, 1);
    @(posedge clk);
    #1;
    out_ctrl_in_ctrl_done = 1'b0;
    @(negedge clk);
    check("dly_done_released", in_ctrl_out_ctrl_done, 0);
    check("dly_ready_again", encoder_src_line_rdy, 1);

    // Codeword 2: random ready, with the peer's done held high throughout.
    rand_rdy              = 1'b1;
    out_ctrl_in_ctrl_done = 1'b1;
    for (int l = 0; l < 7; l++) send_line(l, tl);
    wait_done(td);
    check("cw2_queue_empty", q.size(), 0);
    @(negedge clk);
    check("fast_done_one_cycle", in_ctrl_out_ctrl_done, 0);
    check("fast_ready_again", encoder_src_line_rdy, 1);
    rand_rdy              = 1'b0;
    out_ctrl_in_ctrl_done = 1'b0;

    // Codeword 3: reset while line 3 is being sent.
    for (int l = 0; l < 4; l++) send_line(l, tl);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_line_rdy", encoder_src_line_rdy, 1);
    check("midrst_byte_val", in_ctrl_encoder_byte_val, 0);
    check("midrst_byte", in_ctrl_encoder_byte, 0);
    check("midrst_last", in_ctrl_encoder_byte_last, 0);
    check("midrst_done", in_ctrl_out_ctrl_done, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    done_cycles = 0;

    // Codeword 4: a fresh codeword after the reset, with the last flag on its 223rd byte.
    for (int l = 0; l < 7; l++) send_line(l, tl);
    check("no_spurious_done", done_cycles, 0);
    wait_done(td);
    check("cw4_queue_empty", q.size(), 0);
    @(posedge clk);
    #1;
    out_ctrl_in_ctrl_done = 1'b1;
    @(posedge clk);
    #1;
    out_ctrl_in_ctrl_done = 1'b0;
    @(negedge clk);
    check("cw4_ready_again", encoder_src_line_rdy, 1);

    // Small instance: 1-byte lines and 3-byte codewords.
    send_small(8'hA1, 1'b0);
    send_small(8'hB2, 1'b0);
    send_small(8'hC3, 1'b1);
    begin
      int k;
      k = 0;
      while (!s_done && k < BOUND) begin
        @(negedge clk);
        k++;
      end
    end
    check("s_done_seen", s_done, 1);
    check("s_done_line_rdy", s_line_rdy, 0);
    check("s_queue_empty", sq.size(), 0);
    @(posedge clk);
    #1;
    s_peer_done = 1'b1;
    @(posedge clk);
    #1;
    s_peer_done = 1'b0;
    @(negedge clk);
    check("s_done_released", s_done, 0);
    check("s_ready_again", s_line_rdy, 1);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/rs_encode_line_in_ctrl.md
Name: rs_encode_line_in_ctrl

Overview:
Input-side line controller for the Reed-Solomon encoder. It accepts fixed-width data lines from the upstream source, stores each line, and feeds it byte by byte to the encoder core. It marks the last data byte of each codeword. After the final data byte of a codeword it runs the done handshake with the encoder's line-out controller, and only then accepts the next codeword.

Parameters:
LINE_BYTES, 32, bytes per input line; line width LINE_W = 8*LINE_BYTES; legal range >= 1
DATA_BYTES, 223, data bytes per codeword (k); legal range 1..254; the remaining bytes of the final line are discarded

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-low; rst=0 resets the block
src_encoder_line_val  in  1  input line valid
encoder_src_line_rdy  out  1  input line ready
src_encoder_line_data  in  LINE_W  line data; byte i = bits [LINE_W-1-8*i -: 8], so byte 0 is at the MSB end
in_ctrl_encoder_byte_val  out  1  byte valid to encoder core
encoder_in_ctrl_byte_rdy  in  1  encoder core ready
in_ctrl_encoder_byte  out  8  data byte
in_ctrl_encoder_byte_last  out  1  high with the last data byte of the codeword (byte DATA_BYTES-1)
in_ctrl_out_ctrl_done  out  1  input side finished with the current codeword
out_ctrl_in_ctrl_done  in  1  line-out controller finished with the current codeword

Behaviour:
- Derived constants: NUM_LINES = ceil(DATA_BYTES/LINE_BYTES). LAST_LINE_BYTES = DATA_BYTES - (NUM_LINES-1)*LINE_BYTES.
- Registers:
  - line_reg (LINE_W)
  - byte_idx (clog2(LINE_BYTES), minimum 1 bit)
  - byte_cnt (clog2(DATA_BYTES+1))
  - state
- Reset (rst=0, asynchronous): state=READY; line_reg=0; byte_idx=0; byte_cnt=0. Every output except encoder_src_line_rdy is 0; encoder_src_line_rdy is 1 because READY drives it combinationally.
- A handshake completes on a rising edge where val and rdy are both 1.
- All outputs are Moore outputs (decoded from state and registers only). No combinational path from any input to any output.
- in_ctrl_encoder_byte = byte byte_idx of line_reg.
- in_ctrl_encoder_byte_last = (byte_cnt == DATA_BYTES-1) while in SEND_BYTES; 0 in every other state.
- States:
  - READY: encoder_src_line_rdy=1. On line handshake: line_reg <= data, byte_idx <= 0, byte_cnt <= 0, go to SEND_BYTES.
  - SEND_BYTES: in_ctrl_encoder_byte_val=1. On byte handshake, in this priority order:
    - If byte_cnt == DATA_BYTES-1: go to DONE_WAIT; byte_idx and byte_cnt hold. This takes precedence even when byte_idx < LINE_BYTES-1; the leftover bytes of the line are dropped.
    - Else if byte_idx == LINE_BYTES-1: byte_cnt++, byte_idx <= 0, go to LINE_IN_WAIT.
    - Else: byte_cnt++, byte_idx++.
    - Without a handshake, hold everything; byte and last stay stable while val is high.
  - LINE_IN_WAIT: encoder_src_line_rdy=1. On line handshake: line_reg <= data, go to SEND_BYTES; byte_cnt keeps its value.
  - DONE_WAIT: in_ctrl_out_ctrl_done=1; encoder_src_line_rdy=0. When out_ctrl_in_ctrl_done=1: byte_cnt <= 0, byte_idx <= 0, go to READY. If the peer is already asserting done, DONE_WAIT lasts exactly one cycle.
- Timing: the first byte is valid the cycle after its line is accepted. Throughput is one byte per cycle, with one idle cycle per line boundary; there is no line prefetch.
- Lines are never accepted in SEND_BYTES or DONE_WAIT. Byte val is never high in READY, LINE_IN_WAIT or DONE_WAIT.
- Only the codeword's own lines are accepted; each codeword starts on a fresh line.
- Counters never wrap: byte_cnt saturates at DATA_BYTES-1 through DONE_WAIT.
- Reset mid-operation: the partial codeword is abandoned, the next accepted line is treated as line 0 of a new codeword, and no done is issued for the abandoned codeword.
- Illegal state encoding: outputs X in simulation; next state X.
- Assertions:
  - in_ctrl_encoder_byte_val and encoder_src_line_rdy are never both 1.
  - in_ctrl_encoder_byte and in_ctrl_encoder_byte_last are stable while byte_val=1 and byte_rdy=0.

Test Plan:
- Defaults, lines L0..L6 with byte value = (line*32+idx)&0xFF, byte_rdy tied 1 -> exactly 223 bytes out, equal to 0x00..0xDE in order. Last is high only on byte 0xDE (line 6, idx 30); line 6 idx 31 is never presented. Line-boundary gaps of 1 cycle each; DONE_WAIT is entered after byte 222.
- Same stimulus, byte_rdy random at 50% -> identical byte sequence. Byte, last and val are held stable on every stall cycle. The line is not consumed early.
- DATA_BYTES=64, LINE_BYTES=32 -> 2 lines, last on line 1 idx 31. No third line is accepted; line rdy stays 0 in DONE_WAIT.
- Done handshake, out_ctrl_in_ctrl_done delayed 5 cycles -> in_ctrl_out_ctrl_done high for 6 cycles, then READY with line rdy=1. With peer done held high throughout -> DONE_WAIT lasts 1 cycle, then the next codeword starts correctly.
- Reset asserted (rst=0) mid-line 3, then released -> all outputs 0 and line rdy=1 immediately. The next codeword starts at byte_cnt 0 with last on its 223rd byte; no spurious done.
- LINE_BYTES=1, DATA_BYTES=3 -> 3 line handshakes, 3 bytes, last on byte 3, then the done handshake.
